uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter that serializes the SoC console output onto a single `txd` line.
- It is the transmit end of the console link. The simulation bench's UART monitor is the receiving end that decodes `txd`.
- The bus side pushes bytes through a valid/ready write port into a small FIFO.
- A serializer drains the FIFO at a fixed bit period set by a clock divider.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be ≥ 2.
- FIFO_DEPTH, 4: FIFO entries. Must be a power of two.
- DEPTH_LOG2, 2: log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  a byte is offered on wr_data.
- wr_data  input  8  byte to transmit.
- wr_ready  output  1  FIFO can accept a byte this cycle.
- txd  output  1  serial output; idles high.
- busy  output  1  a frame is in progress or the FIFO is non-empty.
- level  output  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset values (rst_n low, asynchronous): txd=1, wr_ready=1, busy=0, level=0. The FIFO is flushed, the serializer returns to IDLE, and the bit counter and divider clear.
- Reset asserted mid-frame: txd goes high immediately without waiting for a clock. Partial frames are abandoned and nothing resumes after reset.
- Write handshake: a byte is accepted on a rising edge where wr_valid && wr_ready.
  - wr_ready = (level < FIFO_DEPTH) and is combinational from registered level.
  - There is no pass-through when full. A push is refused while level == FIFO_DEPTH, even if a pop occurs in the same cycle.
  - wr_data is sampled only on acceptance.
- FIFO: circular buffer with read and write pointers of DEPTH_LOG2 bits that wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge leave level unchanged.
  - level never exceeds FIFO_DEPTH and never underflows.
- Serializer FSM:
  - IDLE: txd=1. On an edge where level != 0: pop the head byte into the shift register, go to START, drive txd=0.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = shift[0]. Hold each bit for CLKS_PER_BIT cycles, then shift right. After bit 7 completes, go to STOP. Bits are sent LSB first.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the final cycle:
    - if level != 0, pop and go directly to START with no idle gap;
    - otherwise go to IDLE.
- Latency: a byte accepted at edge N into an empty FIFO with the serializer in IDLE is popped at edge N+1. txd falls after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Divider: a counter of width ceil(log2(CLKS_PER_BIT)) counts 0..CLKS_PER_BIT-1. It reloads at every bit boundary and is held at 0 in IDLE.
- txd is driven from a register, so it is glitch-free.
- busy = (state != IDLE) || (level != 0). It is registered-derived and has no combinational input path.

Test Plan:
- Single byte, CLKS_PER_BIT=4:
  - Stimulus: reset, then write 0x55.
  - Required: txd goes low one cycle after acceptance, then shows 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles (40 cycles total). busy drops the cycle after the stop bit ends.
- Back-to-back frames:
  - Stimulus: write 0xA5 then 0x3C on consecutive cycles.
  - Required: 80 contiguous frame cycles with txd never idle between the frames. The decoded bytes are 0xA5 and 0x3C in order.
- Full FIFO:
  - Stimulus: hold wr_valid high with bytes 0x01..0x06.
  - Required: 0x01 is popped immediately and 0x02..0x05 fill the FIFO (level=4, wr_ready=0). 0x06 stalls until the frame for 0x01 ends. All six bytes appear on txd in order.
- Simultaneous push and pop at full:
  - Stimulus: with level=4 at the STOP-end cycle, assert wr_valid.
  - Required: the write is refused that cycle and level reads 3.
  - Stimulus: on the following cycle, write again.
  - Required: the write is accepted and level returns to 4. Pointer wrap is verified over 12 bytes with no loss or duplication.
- Reset mid-frame:
  - Stimulus: pull rst_n low during the DATA bit 3 of 0xF0, while two bytes are queued.
  - Required: txd=1 and level=0 immediately, with no clock needed. After release, txd stays high until a new write, and only the new byte is transmitted.
- Idle stability:
  - Stimulus: no writes for 1000 cycles after reset.
  - Required: txd=1, busy=0, level=0, wr_ready=1 throughout.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO drained by a
// fixed-rate serializer; txd idles high and is driven from a register.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_ready,
  output logic                  txd,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                  DIV_W    = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                r_state, w_state_nxt;
  logic [DIV_W-1:0]      r_div, w_div_nxt;
  logic [2:0]            r_bit, w_bit_nxt;
  logic [7:0]            r_shift, w_shift_nxt;
  logic                  r_txd, w_txd_nxt;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_push, w_pop, w_bit_end;

  // Push is gated by the registered level only, so a full FIFO refuses
  // a write even on the edge that pops.
  assign wr_ready  = (r_level < LVL_FULL);
  assign w_push    = wr_valid && wr_ready;
  assign w_bit_end = (r_div == DIV_LAST);
  assign txd       = r_txd;
  assign level     = r_level;
  assign busy      = (r_state != S_IDLE) || (r_level != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_bit_end ? '0 : r_div + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        w_txd_nxt = 1'b1;
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        w_txd_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_txd_nxt   = r_shift[0];
        end
      end
      S_DATA: begin
        w_txd_nxt = r_shift[0];
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_txd_nxt = r_shift[1];
          end
        end
      end
      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_level != '0) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at CLKS_PER_BIT=4: written bytes are
// queued as expected frames and a txd decoder pops and compares them.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       txd;
  logic       busy;
  logic [2:0] level;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic       mon_abort;

  uart_tx_fifo #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4),
    .DEPTH_LOG2  (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .txd     (txd),
    .busy    (busy),
    .level   (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves wr_valid high so callers can stream bytes back to back.
  task automatic push(input logic [7:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!wr_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      check("push_timeout", 32'(d), 32'hFFFF_FFFF);
    end else begin
      tick();
      exp_q.push_back(d);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'(n), 32'(budget) - 1);
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic mtick();
    @(posedge clk);
    #1;
    if (!rst_n) mon_abort = 1'b1;
  endtask

  // Decoder: first low sample is start-bit cycle 0; bits sampled mid-period.
  initial begin
    logic [7:0] b;
    logic       stopb;
    logic [7:0] e;
    forever begin
      mtick();
      if (rst_n && txd == 1'b0) begin
        mon_abort = 1'b0;
        b     = '0;
        stopb = 1'b0;
        repeat (2) mtick();
        for (int i = 0; i < 9; i++) begin
          repeat (4) mtick();
          if (mon_abort) break;
          if (i < 8) b[i] = txd;
          else       stopb = txd;
        end
        if (!mon_abort) begin
          mtick();
          if (exp_q.size() == 0) begin
            check("rx_unexpected", 32'(b), 32'h100);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(b), 32'(e));
            check("rx_stop", 32'(stopb), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]  f55;
    logic [19:0] fab;
    int          t01;
    int          t06;
    f55 = 10'b1010101010;
    fab = {10'b1001111000, 10'b1101001010};

    #2 rst_n = 1'b0;
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      tick();
      check("idle", 32'({txd, busy, level, wr_ready}), 32'b100001);
    end

    push(8'h55);
    wr_valid = 1'b0;
    check("single_level", 32'(level), 32'd1);
    check("single_txd_pre", 32'(txd), 32'd1);
    tick();
    for (int k = 0; k < 40; k++) begin
      check("single_txd", 32'(txd), 32'(f55[k/4]));
      if (k == 39) check("single_busy_stop", 32'(busy), 32'd1);
      tick();
    end
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_txd_end", 32'(txd), 32'd1);
    wait_idle(200);

    push(8'hA5);
    push(8'h3C);
    wr_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      check("b2b_txd", 32'(txd), 32'(fab[k/4]));
      tick();
    end
    check("b2b_busy_end", 32'(busy), 32'd0);
    wait_idle(200);

    push(8'h01);
    t01 = cyc;
    push(8'h02);
    push(8'h03);
    push(8'h04);
    push(8'h05);
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(wr_ready), 32'd0);
    push(8'h06);
    t06 = cyc;
    wr_valid = 1'b0;
    check("stall_06", 32'(t06 - t01), 32'd42);
    while (cyc < t01 + 80) tick();
    check("pp_level_pre", 32'(level), 32'd4);
    check("pp_ready_pre", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 8'h07;
    tick();
    check("pp_refused_level", 32'(level), 32'd3);
    check("pp_ready_post", 32'(wr_ready), 32'd1);
    exp_q.push_back(8'h07);
    tick();
    check("pp_accept_level", 32'(level), 32'd4);
    for (int d = 8; d <= 12; d++) push(8'(d));
    wr_valid = 1'b0;
    wait_idle(1000);

    push(8'hF0);
    push(8'h11);
    push(8'h22);
    wr_valid = 1'b0;
    repeat (16) tick();
    check("mid_txd_bit3", 32'(txd), 32'd0);
    check("mid_level", 32'(level), 32'd2);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("post_rst_idle", 32'({txd, busy}), 32'b10);
    end
    push(8'h99);
    wr_valid = 1'b0;
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
